// File: rtl/nibbler_pkg.sv
// Shared nibbler constants: program address/data widths, ROM field widths,
// and the loader FSM state encoding.
package nibbler_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 1 << ADDR_W;

  // Program byte layout: instruction nibble on top, operand nibble below.
  localparam int INSTR_W = 4;
  localparam int OPRND_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } load_state_t;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [DATA_W-1:0] b);
    return b[DATA_W-1 -: INSTR_W];
  endfunction

  function automatic logic [OPRND_W-1:0] oprnd_of(input logic [DATA_W-1:0] b);
    return b[OPRND_W-1:0];
  endfunction

endpackage

// File: rtl/nibbler_prog_ram.sv
// Program memory: synchronous write, asynchronous read. The array has no
// reset so an image survives a system reset.
module nibbler_prog_ram
  import nibbler_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: one byte per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/nibbler_prog_loader.sv
// Streams a program image into program memory from address 0 and holds the
// CPU in reset until the image is complete.
module nibbler_prog_loader
  import nibbler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              overflow,
  output logic [ADDR_W:0]   load_count
);

  load_state_t       state, state_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              at_end;

  assign accept = in_valid && in_ready;
  // Last address reached without an in_last marker: image is truncated.
  assign at_end = (wr_addr == ADDR_MAX);

  // State register; cpu_reset follows the next state so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      cpu_reset <= (state_nxt != RUN);
    end
  end

  // Next-state and handshake; start from any state (re)begins a load.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    loaded    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = !start;
        if (start)                        state_nxt = LOAD;
        else if (accept && (in_last || at_end)) state_nxt = RUN;
      end
      RUN: begin
        loaded = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer, byte count and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr    <= '0;
      load_count <= '0;
      overflow   <= 1'b0;
    end else if (start) begin
      wr_addr    <= '0;
      load_count <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      wr_addr    <= wr_addr + 1'b1;
      load_count <= load_count + 1'b1;
      if (at_end && !in_last) overflow <= 1'b1;
    end
  end

  nibbler_prog_ram u_ram (
    .clk (clk),
    .we  (accept),
    .wa  (wr_addr),
    .wd  (in_data),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Scoreboard bench for nibbler_prog_loader: every accepted beat is queued
// as (addr, byte) and checked later through the read port.
module tb_nibbler_prog_loader;
  import nibbler_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              cpu_reset;
  logic              loaded;
  logic              overflow;
  logic [ADDR_W:0]   load_count;

  nibbler_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_reset  (cpu_reset),
    .loaded     (loaded),
    .overflow   (overflow),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } sb_t;

  sb_t               sb_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] m_addr;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record an expected write; an older entry for the same address is stale.
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    for (int i = sb_q.size() - 1; i >= 0; i--)
      if (sb_q[i].a == a) sb_q.delete(i);
    sb_q.push_back('{a: a, d: d});
    ref_mem[a] = d;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    #1 chk("in_ready_load", in_ready, 1);
    @(posedge clk);
    push(m_addr, d);
    m_addr = m_addr + 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    m_addr = '0;
  endtask

  task automatic drain();
    sb_t e;
    gap();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr = e.a;
      #1 chk($sformatf("mem[%0d]", e.a), rd_data, e.d);
    end
  endtask

  initial begin
    m_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_load_count", load_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // Back-to-back three-byte image.
    pulse_start();
    chk("t1_cpu_reset_held", cpu_reset, 1);
    send_beat(8'h4A, 1'b0);
    send_beat(8'hD0, 1'b0);
    send_beat(8'hC0, 1'b1);
    #1;
    chk("t1_loaded", loaded, 1);
    chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_load_count", load_count, 3);
    chk("t1_run_in_ready", in_ready, 0);
    drain();

    // Gapped stream: idle cycles must not write or count.
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      send_beat(8'(i), i == 5);
      if (i < 5) begin
        gap();
        #1 chk("t2_gap_count", load_count, 32'(i));
      end
    end
    gap();
    chk("t2_load_count", load_count, 5);
    chk("t2_loaded", loaded, 1);
    drain();

    // Full memory without in_last.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send_beat(8'(i), 1'b0);
    gap();
    chk("t3_overflow", overflow, 1);
    chk("t3_load_count", load_count, DEPTH);
    chk("t3_loaded", loaded, 1);
    chk("t3_cpu_reset", cpu_reset, 0);
    // A beat offered in RUN is ignored.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    #1 chk("t3_run_ready", in_ready, 0);
    @(posedge clk);
    gap();
    chk("t3_count_hold", load_count, DEPTH);
    drain();

    // Restart mid-load: the start-cycle beat is rejected.
    pulse_start();
    chk("t4_overflow_clr", overflow, 0);
    for (int i = 0; i < 10; i++) send_beat(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
    #1 chk("t4_ready_blocked", in_ready, 0);
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    m_addr = '0;
    chk("t4_count_clr", load_count, 0);
    send_beat(8'h77, 1'b1);
    gap();
    chk("t4_load_count", load_count, 1);
    drain();

    // Reload from RUN; same-cycle read shows old byte, then new.
    pulse_start();
    chk("t5_cpu_reset", cpu_reset, 1);
    chk("t5_loaded", loaded, 0);
    @(negedge clk);
    rd_addr = '0;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    #1 chk("t5_old_byte", rd_data, ref_mem[0]);
    @(posedge clk);
    push(m_addr, 8'hAA);
    m_addr = m_addr + 1'b1;
    #1 chk("t5_new_byte", rd_data, 8'hAA);
    chk("t5_loaded_run", loaded, 1);
    gap();
    rd_addr = 12'd1;
    #1 chk("t5_keep_mem1", rd_data, ref_mem[1]);
    drain();

    // Asynchronous reset in the middle of a load.
    pulse_start();
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_cpu_reset", cpu_reset, 1);
    chk("t6_loaded", loaded, 0);
    chk("t6_load_count", load_count, 0);
    chk("t6_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
